seq_detector: RTL and testbench
===============================

# seq_detector

Serial-bitstream pattern detector that feeds the 4-bit event counter stage directly downstream. It samples one qualified input bit per clock, tracks the most recent PATTERN_W bits, and emits a single-cycle `detect` pulse whenever those bits equal PATTERN. `detect` drives the counter's increment enable, so the counter counts pattern occurrences.

## Interface
- PATTERN_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011: target pattern. MSB is the oldest bit; LSB is the newest bit.

- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous active-high reset.
- bit_valid  in  1  qualifies bit_in this cycle; no state changes when low.
- bit_in  in  1  serial data bit, sampled only when bit_valid=1.
- clear  in  1  synchronous flush of history; same effect as rst on all outputs.
- detect  out  1  registered one-cycle pulse per match; this is the counter increment enable.
- hist  out  PATTERN_W  shift history, newest bit in the LSB.
- fill  out  $clog2(PATTERN_W+1)  number of valid bits in hist; saturates at PATTERN_W.

## Operation
- Reset and clear: on rst=1 or clear=1 at a clock edge, hist=0, fill=0 and detect=0. rst and clear take priority over bit_valid.
- Shift: when bit_valid=1, hist <= {hist[PATTERN_W-2:0], bit_in}.
- Fill count: when bit_valid=1, fill <= min(fill+1, PATTERN_W). When bit_valid=0, hist and fill hold.
- Match condition (combinational): bit_valid && (fill >= PATTERN_W-1) && ({hist[PATTERN_W-2:0], bit_in} == PATTERN).
  - The fill gate stops the reset-zero history from aliasing a pattern that contains leading zeros.
- detect <= match on every cycle. It is therefore never high for two consecutive cycles unless matches occur on consecutive valid bits, which overlap mode allows (for example, an all-ones pattern).
- Implementation structure: either an explicit FSM with PATTERN_W+1 fill states (EMPTY, 1..PATTERN_W-1, ARMED) plus the shift register, or an equivalent counter. The observable behaviour above is the contract; the choice between the two is free.
- Widths:
  - fill arithmetic saturates and never wraps.
  - hist shifts its oldest bit out and discards it.

## Timing
- Latency: detect asserts in the cycle immediately after the edge that samples the completing bit. That is 1 clock.
- No backpressure: every valid bit is accepted, and the block is always ready.
- Gaps: bit_valid may drop for any number of cycles mid-pattern. Partial progress is held across the gap.
- Simultaneous clear and matching bit: clear wins. detect=0 on the next cycle and the bit is discarded.
- Reset mid-operation: a detect pulse already pending in the register is cancelled at the reset edge.
- Downstream contract: the counter increments once per detect-high cycle. This block guarantees a single registered pulse per match.

## Configuration
- Macro: SEQ_DETECTOR_NONOVERLAP_EN.
- Undefined (default): overlapping detection. After a match, history and fill continue normally, so the tail of one match can start the next.
- Defined: non-overlapping detection. On a match, fill <= 0 in that same cycle. hist still shifts in the new bit, but fill gates it out. A new match therefore needs PATTERN_W fresh bits.

## Test plan
All scenarios use PATTERN=4'b1011 and PATTERN_W=4 unless stated.
- Reset: assert rst for 2 cycles with random bit_in and bit_valid=1 -> detect=0, hist=0000 and fill=0 throughout, and for one cycle after release.
- Basic match: bits 1,0,1,1 on 4 consecutive valid cycles -> detect=1 only in cycle 5, hist=1011 and fill=4.
- Overlap: stream 1,0,1,1,0,1,1 -> default build gives detect pulses in cycles 5 and 8 (two counts); SEQ_DETECTOR_NONOVERLAP_EN build gives a single pulse in cycle 5.
- Valid gaps: send 1,0, then bit_valid=0 for 3 cycles with bit_in=1, then 1,1 -> exactly one detect, in the cycle after the final bit; hist and fill frozen during the gap.
- Clear mid-pattern: send 1,0,1, then clear together with bit_in=1 and bit_valid=1 -> no detect and fill=0; then 1,0,1,1 -> detect once.
- Leading-zero alias: PATTERN=4'b0001, reset, then a single valid 1 -> no detect (fill gate); then 0,0,0,1 -> detect once.

Source files
------------

// File: rtl/seq_detector.sv
// seq_detector: serial-bitstream pattern detector.
// Samples one qualified bit per clock, keeps the last PATTERN_W bits and
// emits a registered one-cycle detect pulse when they equal PATTERN.
// detect feeds the increment enable of the downstream event counter.
// Optional build macro: SEQ_DETECTOR_NONOVERLAP_EN selects non-overlapping
// detection (fill is flushed on each match). Overlapping detection is the
// default when the macro is undefined.
module seq_detector #(
    parameter int                     PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0]   PATTERN   = 4'b1011,
    localparam int                    FILL_W    = $clog2(PATTERN_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 clear,
    output logic                 detect,
    output logic [PATTERN_W-1:0] hist,
    output logic [FILL_W-1:0]    fill
);

    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_ARMED = FILL_W'(PATTERN_W - 1);
    localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);

    logic [PATTERN_W-1:0] shifted;
    logic [PATTERN_W-1:0] hist_next;
    logic [FILL_W-1:0]    fill_next;
    logic                 match;

    // Next-state logic: candidate history, match test and saturating fill.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shifted   = {hist[PATTERN_W-2:0], bit_in};
        hist_next = hist;
        fill_next = fill;
        // The fill gate keeps the zeroed reset history from aliasing a
        // pattern with leading zeros.
        match     = bit_valid && (fill >= FILL_ARMED) && (shifted == PATTERN);

        if (bit_valid) begin
            hist_next = shifted;
            if (fill != FILL_FULL) begin
                fill_next = fill + FILL_ONE;
            end
`ifdef SEQ_DETECTOR_NONOVERLAP_EN
            // A match consumes its bits: the next match needs a full
            // window of fresh bits, so the stale tail is gated out by fill.
            if (match) begin
                fill_next = '0;
            end
`endif
        end
    end

    // State register; rst and clear both flush and take priority over data.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist   <= '0;
            fill   <= '0;
            detect <= 1'b0;
        end else begin
            hist   <= hist_next;
            fill   <= fill_next;
            detect <= match;
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Directed self-checking bench for seq_detector (PATTERN=4'b1011) plus a
// second instance with PATTERN=4'b0001 for the leading-zero alias case.
// Expected values follow SEQ_DETECTOR_NONOVERLAP_EN when it is defined.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       bit_valid;
    logic       bit_in;
    logic       detect;
    logic [3:0] hist;
    logic [2:0] fill;

    logic       bit_valid2;
    logic       bit_in2;
    logic       detect2;
    logic [3:0] hist2;
    logic [2:0] fill2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clear     (clear),
        .detect    (detect),
        .hist      (hist),
        .fill      (fill)
    );

    seq_detector #(.PATTERN_W(4), .PATTERN(4'b0001)) dut_lz (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid2),
        .bit_in    (bit_in2),
        .clear     (clear),
        .detect    (detect2),
        .hist      (hist2),
        .fill      (fill2)
    );

`ifdef SEQ_DETECTOR_NONOVERLAP_EN
    localparam bit NONOVERLAP = 1'b1;
`else
    localparam bit NONOVERLAP = 1'b0;
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, and settle just after the edge.
    task automatic step(input logic v, input logic b, input logic c, input logic r);
        bit_valid = v;
        bit_in    = b;
        clear     = c;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step_lz(input logic v, input logic b);
        bit_valid2 = v;
        bit_in2    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic d, input logic [3:0] h, input logic [2:0] f);
        check({tag, ".detect"}, 16'(detect), 16'(d));
        check({tag, ".hist"},   16'(hist),   16'(h));
        check({tag, ".fill"},   16'(fill),   16'(f));
    endtask

    initial begin
        logic [6:0] ovl_bits;
        logic [6:0] ovl_exp;

        bit_valid2 = 1'b0;
        bit_in2    = 1'b0;

        // Reset held for two cycles with valid random data.
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        chk_all("reset_c1", 1'b0, 4'b0000, 3'd0);
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        chk_all("reset_c2", 1'b0, 4'b0000, 3'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("reset_release", 1'b0, 4'b0000, 3'd0);

        // Basic match 1,0,1,1.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("basic_b1", 1'b0, 4'b0001, 3'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("basic_b2", 1'b0, 4'b0010, 3'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("basic_b3", 1'b0, 4'b0101, 3'd3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("basic_b4", 1'b1, 4'b1011, NONOVERLAP ? 3'd0 : 3'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("basic_after.detect", 16'(detect), 16'd0);

        // Overlapping stream 1,0,1,1,0,1,1 (LSB of ovl_bits is sent first).
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("clear_idle", 1'b0, 4'b0000, 3'd0);
        ovl_bits = 7'b1101101;
        ovl_exp  = NONOVERLAP ? 7'b0001000 : 7'b1001000;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, ovl_bits[i], 1'b0, 1'b0);
            check($sformatf("overlap_b%0d.detect", i + 1), 16'(detect), 16'(ovl_exp[i]));
        end
        check("overlap_end.hist", 16'(hist), 16'b1011);
        check("overlap_end.fill", 16'(fill), NONOVERLAP ? 16'd3 : 16'd4);

        // Valid gaps: 1,0, three idle cycles with bit_in=1, then 1,1.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("gap_pre", 1'b0, 4'b0010, 3'd2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk_all($sformatf("gap_idle%0d", i), 1'b0, 4'b0010, 3'd2);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("gap_b3", 1'b0, 4'b0101, 3'd3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("gap_b4", 1'b1, 4'b1011, NONOVERLAP ? 3'd0 : 3'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("gap_after.detect", 16'(detect), 16'd0);

        // Clear together with the completing bit: clear wins.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("clear_win", 1'b0, 4'b0000, 3'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_re_b1.detect", 16'(detect), 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("clr_re_b2.detect", 16'(detect), 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_re_b3.detect", 16'(detect), 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("clr_re_b4", 1'b1, 4'b1011, NONOVERLAP ? 3'd0 : 3'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_re_after.detect", 16'(detect), 16'd0);

        // Reset together with the completing bit cancels the match.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_all("rst_win", 1'b0, 4'b0000, 3'd0);

        // Leading-zero alias on the 4'b0001 instance (just reset above).
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step_lz(1'b1, 1'b1);
        check("lz_single.detect", 16'(detect2), 16'd0);
        check("lz_single.fill",   16'(fill2),   16'd1);
        step_lz(1'b1, 1'b0);
        check("lz_b1.detect", 16'(detect2), 16'd0);
        step_lz(1'b1, 1'b0);
        check("lz_b2.detect", 16'(detect2), 16'd0);
        step_lz(1'b1, 1'b0);
        check("lz_b3.detect", 16'(detect2), 16'd0);
        check("lz_b3.hist",   16'(hist2),   16'b1000);
        step_lz(1'b1, 1'b1);
        check("lz_b4.detect", 16'(detect2), 16'd1);
        check("lz_b4.hist",   16'(hist2),   16'b0001);
        step_lz(1'b0, 1'b0);
        check("lz_after.detect", 16'(detect2), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
